inst_mem_loader: RTL and testbench
==================================

# inst_mem_loader

Parametrised, field-reprogrammable instruction memory for the pipelined MIPS CPU. It replaces the fixed combinational instruction table with a synchronous-read word RAM. A byte-stream programming port lets a host, such as a UART receiver, load a new program without resynthesis. It sits in the IF stage and drives `Instruction` to the IF/ID register. It asserts `cpu_hold` while a load is in progress.

## Interface
- `ADDR_WIDTH`, default 8: word-address bits. Depth `DEPTH = 2**ADDR_WIDTH` words.
- `DATA_WIDTH`, default 32: instruction width. Fixed at 32 for the MIPS core; 4 bytes per word.
- `clk`  in  1  : system clock, rising edge. One clock domain.
- `reset`  in  1  : synchronous, active-high reset.
- `Address`  in  32  : byte address from the PC. Word index = `Address[ADDR_WIDTH+1:2]`.
- `fetch_en`  in  1  : fetch enable. 0 means IF stall, and the output holds.
- `Instruction`  out  32  : registered fetched instruction.
- `Instruction_valid`  out  1  : `Instruction` holds a real fetch.
- `load_start`  in  1  : 1-cycle pulse that begins or restarts programming.
- `load_len`  in  ADDR_WIDTH+1  : number of words to load. Sampled on `load_start`.
- `load_byte`  in  8  : programming byte.
- `load_byte_valid`  in  1  : `load_byte` is offered.
- `load_byte_ready`  out  1  : the block accepts bytes.
- `cpu_hold`  out  1  : a load is active; the CPU must stall or stay held.
- `load_done`  out  1  : 1-cycle pulse when the load completes.
- `load_count`  out  ADDR_WIDTH+1  : words written so far in the current load.

## Operation
- **States.** The FSM has two states, IDLE and LOAD.
  - IDLE → LOAD on `load_start`, with `load_len` ≠ 0.
  - LOAD → IDLE when the final word is written.
  - LOAD → LOAD on `load_start`: restart. Pointer, byte counter and `load_count` go to 0 and any partial word is discarded.
- **load_len clamping.** `load_len` > `DEPTH` is clamped to `DEPTH`.
- **load_len = 0.** `load_start` with `load_len` = 0 stays in IDLE and pulses `load_done` in the next cycle.
- **Byte acceptance.** A byte is accepted on `load_byte_valid && load_byte_ready`. `load_byte_ready` = (state == LOAD).
- **Byte packing.** Bytes are big-endian. The first byte goes to [31:24] and the fourth to [7:0].
- **Word write.** On the 4th accepted byte, the assembled word is written to `mem[ptr]` at that edge. `ptr` and `load_count` then increment.
- **Fetch in IDLE with `fetch_en` = 1.** At the edge, `Instruction` ← `mem[index]` and `Instruction_valid` ← 1.
- **Out-of-range fetch.** If any bit of `Address[31:ADDR_WIDTH+2]` is set, `Instruction` ← 32'h00000000 (nop) and `Instruction_valid` ← 1.
- **Fetch in IDLE with `fetch_en` = 0.** `Instruction` and `Instruction_valid` hold.
- **Fetch in LOAD.** `Instruction` ← 0 and `Instruction_valid` ← 0. Fetch never overlaps a write, so read-during-write is undefined and never exercised.
- **RAM contents.** RAM is not cleared by reset. Its simulation initial content is all zero.
- **Reset.** `reset`, including mid-load:
  - State → IDLE.
  - `ptr`, byte counter and `load_count` → 0; the partial word is dropped.
  - Words already written remain in RAM.
- **Reset values of outputs:**
  - `Instruction` = 0
  - `Instruction_valid` = 0
  - `load_byte_ready` = 0
  - `cpu_hold` = 0
  - `load_done` = 0
  - `load_count` = 0
- **Event priority.** `reset` > `load_start` > byte acceptance > fetch.

## Timing
- **Fetch latency.** Read latency is 1 cycle: `Address` presented at edge N yields `Instruction` after edge N+1.
- **Stall.** Holding `fetch_en` low freezes the output indefinitely.
- **Entering LOAD.** `cpu_hold` and `load_byte_ready` rise in the cycle after the `load_start` edge.
- **Byte throughput.** One byte is accepted per cycle at most. Gaps in `load_byte_valid` are allowed with no timeout.
- **Final word.** For the edge that accepts the final byte:
  - The word is written at that edge.
  - In the following cycle, state = IDLE, `cpu_hold` = 0, `load_byte_ready` = 0 and `load_done` = 1 for exactly one cycle.
  - `load_count` equals the clamped `load_len` and holds until the next `load_start` or `reset`.
- **First fetch after a load.** The first valid fetch can be issued in the `load_done` cycle. Its data appears in the following cycle.

## Test plan
- **Reset.** Assert `reset` for 2 cycles with random inputs → all outputs 0 and state IDLE.
- **Load and fetch.** `load_start` with `load_len` = 3, then bytes 00 00 28 21 20 A4 00 04 8C A5 00 00 → `load_done` pulses once, one cycle after the 12th byte, and `load_count` = 3. Then fetch `Address` 0, 4, 8 → 32'h00002821, 32'h20A40004, 32'h8CA50000 on consecutive cycles, each with `Instruction_valid` = 1.
- **Stall.** After fetching `Address` 4, drop `fetch_en` for 5 cycles while `Address` changes to 8 → `Instruction` stays 32'h20A40004.
- **Out of range.** With `ADDR_WIDTH` = 8, fetch `Address` 32'h00000400 → 32'h00000000 with valid = 1. Fetch `Address` 32'h000003FC → `mem[255]`.
- **Gapped bytes and restart.**
  - Apply random 0–3 cycle gaps in `load_byte_valid` → identical RAM contents.
  - Pulse `load_start` after 2 bytes of a word → the partial word is discarded and the next 4 bytes land at word 0.
- **Reset mid-load and zero length.**
  - `reset` after 5 words of a 10-word load → `cpu_hold` = 0 and words 0–4 are retained.
  - `load_start` with `load_len` = 0 → no LOAD state and a `load_done` pulse in the next cycle.
  - `load_len` = 300 with `ADDR_WIDTH` = 8 → done after 256 words.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Reprogrammable synchronous-read instruction RAM for the IF stage.
// A big-endian byte stream loads words while the CPU is held off.
module inst_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic                  fetch_en,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  Instruction_valid,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic [7:0]            load_byte,
  input  logic                  load_byte_valid,
  output logic                  load_byte_ready,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned PW    = DATA_WIDTH - 8;

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         part_q;
  logic [1:0]            byte_cnt_q;
  logic [CW-1:0]         len_q, len_clamped, count_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  valid_q;
  logic                  accept, word_full, last_word, out_of_range;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic                  unused_addr;

  assign len_clamped  = (load_len > CW'(DEPTH)) ? CW'(DEPTH) : load_len;
  assign fetch_idx    = Address[ADDR_WIDTH+1:2];
  assign out_of_range = |Address[31:ADDR_WIDTH+2];
  assign unused_addr  = ^Address[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: a start (or restart) wins over word completion
  always_comb begin
    state_d = state_q;
    if (load_start)                       state_d = (len_clamped != '0) ? LOAD : IDLE;
    else if (state_q == LOAD && last_word) state_d = IDLE;
  end

  // Output and handshake decode
  always_comb begin
    load_byte_ready = (state_q == LOAD);
    cpu_hold        = (state_q == LOAD);
    accept          = load_byte_ready && load_byte_valid;
    word_full       = accept && (byte_cnt_q == 2'd3);
    last_word       = word_full && ((count_q + CW'(1)) == len_q);
  end

  // Load bookkeeping and the registered fetch port
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      byte_cnt_q <= '0;
      part_q     <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_start) begin
        count_q    <= '0;
        byte_cnt_q <= '0;
        len_q      <= len_clamped;
        done_q     <= (len_clamped == '0);
      end else if (accept) begin
        part_q     <= {part_q[PW-9:0], load_byte};
        byte_cnt_q <= byte_cnt_q + 2'd1;
        if (word_full) begin
          count_q <= count_q + CW'(1);
          done_q  <= last_word;
        end
      end

      if (state_q == LOAD) begin
        instr_q <= '0;
        valid_q <= 1'b0;
      end else if (fetch_en && !load_start) begin
        instr_q <= out_of_range ? '0 : mem[fetch_idx];
        valid_q <= 1'b1;
      end
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (word_full && !load_start && !reset)
      mem[count_q[ADDR_WIDTH-1:0]] <= {part_q, load_byte};
  end

  assign Instruction       = instr_q;
  assign Instruction_valid = valid_q;
  assign load_done         = done_q;
  assign load_count        = count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: random byte streams checked against an array model.
module tb_inst_mem_loader;

  localparam int unsigned AW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic        fetch_en;
  logic [31:0] Instruction;
  logic        Instruction_valid;
  logic        load_start;
  logic [AW:0] load_len;
  logic [7:0]  load_byte;
  logic        load_byte_valid;
  logic        load_byte_ready;
  logic        cpu_hold;
  logic        load_done;
  logic [AW:0] load_count;

  inst_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Address(Address), .fetch_en(fetch_en),
    .Instruction(Instruction), .Instruction_valid(Instruction_valid),
    .load_start(load_start), .load_len(load_len), .load_byte(load_byte),
    .load_byte_valid(load_byte_valid), .load_byte_ready(load_byte_ready),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_count(load_count)
  );

  always #5 clk = ~clk;

  // Reference model: word array plus the progress of the current load
  logic [31:0] ref_mem [256];
  int          m_len, m_cnt, m_nb;
  logic [31:0] m_word;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = 9'(len);
    tick();
    load_start = 1'b0;
    m_len = (len > 256) ? 256 : len;
    m_cnt = 0;
    m_nb  = 0;
    n_cmp++;
    if (m_len == 0) begin
      if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_byte_ready !== 1'b0 || load_count !== 9'd0) begin
        n_err++;
        $display("FAIL start_zero: done=%b hold=%b ready=%b count=%0d, required done=1 hold=0 ready=0 count=0",
                 load_done, cpu_hold, load_byte_ready, load_count);
      end
    end else if (load_done !== 1'b0 || cpu_hold !== 1'b1 || load_byte_ready !== 1'b1 || load_count !== 9'd0) begin
      n_err++;
      $display("FAIL start_load: done=%b hold=%b ready=%b count=%0d, required done=0 hold=1 ready=1 count=0",
               load_done, cpu_hold, load_byte_ready, load_count);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic exp_busy;
    repeat (gap) begin
      load_byte_valid = 1'b0;
      load_byte       = 8'($urandom);
      tick();
    end
    load_byte       = b;
    load_byte_valid = 1'b1;
    fetch_en        = 1'($urandom);
    Address         = $urandom;
    tick();
    load_byte_valid = 1'b0;
    fetch_en        = 1'b0;
    m_word = {m_word[23:0], b};
    m_nb++;
    if (m_nb == 4) begin
      ref_mem[m_cnt] = m_word;
      m_cnt++;
      m_nb = 0;
    end
    exp_busy = (m_cnt != m_len);
    n_cmp++;
    if (load_done !== !exp_busy || cpu_hold !== exp_busy || load_byte_ready !== exp_busy ||
        load_count !== 9'(m_cnt) || Instruction !== 32'h0 || Instruction_valid !== 1'b0) begin
      n_err++;
      $display("FAIL byte_step: done=%b hold=%b ready=%b count=%0d instr=%h valid=%b, required done=%b hold=%b ready=%b count=%0d instr=0 valid=0",
               load_done, cpu_hold, load_byte_ready, load_count, Instruction, Instruction_valid,
               !exp_busy, exp_busy, exp_busy, m_cnt);
    end
  endtask

  task automatic check_post_done();
    tick();
    n_cmp++;
    if (load_done !== 1'b0 || cpu_hold !== 1'b0 || load_count !== 9'(m_len)) begin
      n_err++;
      $display("FAIL post_done: done=%b hold=%b count=%0d, required done=0 hold=0 count=%0d",
               load_done, cpu_hold, load_count, m_len);
    end
  endtask

  task automatic fetch(input logic [31:0] addr);
    logic [31:0] exp;
    Address  = addr;
    fetch_en = 1'b1;
    tick();
    exp = (|addr[31:10]) ? 32'h0 : ref_mem[addr[9:2]];
    n_cmp++;
    if (Instruction !== exp || Instruction_valid !== 1'b1) begin
      n_err++;
      $display("FAIL fetch %h: instr=%h valid=%b, required instr=%h valid=1",
               addr, Instruction, Instruction_valid, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      Address         = $urandom;
      fetch_en        = 1'($urandom);
      load_start      = 1'($urandom);
      load_len        = 9'($urandom);
      load_byte       = 8'($urandom);
      load_byte_valid = 1'($urandom);
      tick();
    end
    n_cmp++;
    if (Instruction !== 32'h0 || Instruction_valid !== 1'b0 || load_byte_ready !== 1'b0 ||
        cpu_hold !== 1'b0 || load_done !== 1'b0 || load_count !== 9'd0) begin
      n_err++;
      $display("FAIL reset: instr=%h valid=%b ready=%b hold=%b done=%b count=%0d, required all 0",
               Instruction, Instruction_valid, load_byte_ready, cpu_hold, load_done, load_count);
    end
    reset = 1'b0; load_start = 1'b0; load_byte_valid = 1'b0; fetch_en = 1'b0;
    tick();
  endtask

  task automatic test_load_fetch();
    logic [7:0]  prog [12] = '{8'h00, 8'h00, 8'h28, 8'h21, 8'h20, 8'hA4,
                               8'h00, 8'h04, 8'h8C, 8'hA5, 8'h00, 8'h00};
    logic [31:0] golden [3] = '{32'h00002821, 32'h20A40004, 32'h8CA50000};
    start_load(3);
    for (int i = 0; i < 12; i++) send_byte(prog[i], 0);
    check_post_done();
    for (int i = 0; i < 3; i++) begin
      fetch(32'(4 * i));
      n_cmp++;
      if (Instruction !== golden[i]) begin
        n_err++;
        $display("FAIL program_word%0d: got %h, required %h", i, Instruction, golden[i]);
      end
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_stall();
    fetch(32'd4);
    fetch_en = 1'b0;
    Address  = 32'd8;
    repeat (5) begin
      tick();
      n_cmp++;
      if (Instruction !== 32'h20A40004 || Instruction_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall: instr=%h valid=%b, required instr=20a40004 valid=1",
                 Instruction, Instruction_valid);
      end
    end
  endtask

  task automatic test_gapped();
    int          len;
    logic [7:0]  data [48];
    len = $urandom_range(4, 12);
    for (int i = 0; i < 48; i++) data[i] = 8'($urandom);
    for (int pass = 0; pass < 2; pass++) begin
      start_load(len);
      for (int i = 0; i < 4 * len; i++) send_byte(data[i], (pass == 0) ? $urandom_range(0, 3) : 0);
      check_post_done();
      for (int w = 0; w < len; w++) fetch(32'(4 * w));
      fetch_en = 1'b0;
    end
  endtask

  task automatic test_restart();
    start_load(4);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 1);
    start_load(2);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), $urandom_range(0, 2));
    check_post_done();
    fetch(32'd0);
    fetch(32'd4);
    fetch_en = 1'b0;
  endtask

  task automatic test_reset_midload();
    start_load(10);
    for (int i = 0; i < 22; i++) send_byte(8'($urandom), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_len = 0; m_cnt = 0; m_nb = 0;
    n_cmp++;
    if (cpu_hold !== 1'b0 || load_byte_ready !== 1'b0 || load_count !== 9'd0 ||
        load_done !== 1'b0 || Instruction !== 32'h0 || Instruction_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midload: hold=%b ready=%b count=%0d done=%b instr=%h valid=%b, required all 0",
               cpu_hold, load_byte_ready, load_count, load_done, Instruction, Instruction_valid);
    end
    for (int w = 0; w < 5; w++) fetch(32'(4 * w));
    fetch_en = 1'b0;
  endtask

  task automatic test_zero_len();
    start_load(0);
    tick();
    n_cmp++;
    if (load_done !== 1'b0 || cpu_hold !== 1'b0 || load_byte_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_after: done=%b hold=%b ready=%b, required 0 0 0",
               load_done, cpu_hold, load_byte_ready);
    end
  endtask

  task automatic test_clamp();
    logic [31:0] a;
    start_load(300);
    for (int i = 0; i < 1024; i++) send_byte(8'($urandom), 0);
    check_post_done();
    fetch(32'h000003FC);
    fetch(32'h00000400);
    for (int i = 0; i < 20; i++) begin
      a = {22'h0, 10'($urandom)};
      if ($urandom_range(0, 1) == 1) a[$urandom_range(10, 31)] = 1'b1;
      fetch(a);
    end
    fetch_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    m_len = 0; m_cnt = 0; m_nb = 0; m_word = 32'h0;
    reset = 1'b1; Address = 32'h0; fetch_en = 1'b0; load_start = 1'b0;
    load_len = '0; load_byte = 8'h0; load_byte_valid = 1'b0;
    test_reset();
    test_load_fetch();
    test_stall();
    test_gapped();
    test_restart();
    test_reset_midload();
    test_zero_len();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
